// File: rtl/restoring_div_seq.sv
// Sequential restoring divider: one quotient bit per clock over W iterations.
// The trial subtract/restore runs through a row of W+1 add/sub cells controlled by s and s1.
module restoring_div_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(W + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W:0]    a_q, a_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [W:0]    row_a, row_b, row_sum, row_r, row_c;
   logic          row_s, row_s1;

   assign row_a = {a_q[W-1:0], q_q[W-1]};
   assign row_b = {1'b0, m_q};
   assign row_s = 1'b1;
   assign row_c[0] = row_s;
   // a_q[W] is always 0 because A stays below the divisor; folding it in keeps the sign exact anyway.
   assign row_s1 = row_sum[W] & ~a_q[W];

   generate
      for (genvar gi = 0; gi <= W; gi++) begin : g_cell
         logic bx;
         assign bx          = row_b[gi] ^ row_s;
         assign row_sum[gi] = row_a[gi] ^ bx ^ row_c[gi];
         assign row_r[gi]   = row_s1 ? row_a[gi] : row_sum[gi];
         if (gi < W) begin : g_carry
            assign row_c[gi+1] = (row_a[gi] & bx) | (row_a[gi] & row_c[gi]) | (bx & row_c[gi]);
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = '0;
               q_d   = dividend;
               m_d   = divisor;
               cnt_d = CW'(W);
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = S_DONE;
                  dbz_d   = 1'b1;
                  quot_d  = '1;
                  rem_d   = dividend;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            a_d   = row_r;
            q_d   = {q_q[W-2:0], ~row_s1};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               quot_d  = {q_q[W-2:0], ~row_s1};
               rem_d   = row_r[W-1:0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div_seq.sv
// Self-checking bench for restoring_div_seq: directed vector table, multi-cycle corner sequences
// and randomized operands against an arithmetic reference (/ and %).
module tb_restoring_div_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } vec_t;

   vec_t vecs[9];

   restoring_div_seq #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle; returns #1 after the edge following done.
   // lat counts edges after the accepting edge until done is seen.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output int lat, output int pulses, output logic busy_ok);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat      = 0;
      busy_ok  = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!busy) busy_ok = 1'b0;
      q      = quotient;
      r      = remainder;
      z      = div_by_zero;
      pulses = done ? 1 : 0;
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (busy) busy_ok = 1'b0;
   endtask

   initial begin
      logic [W-1:0] q, r, a, b;
      logic         z, bok;
      int           lat, pulses, cnt;

      vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, W};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, W};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, W};
      vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, W};
      vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, W};
      vecs[5] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 0};
      vecs[6] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, W};
      vecs[7] = '{8'd254, 8'd128, 8'd1,   8'd126, 1'b0, W};
      vecs[8] = '{8'd7,   8'd2,   8'd3,   8'd1,   1'b0, W};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset quotient", 32'(quotient), 0);
      check("reset remainder", 32'(remainder), 0);
      check("reset div_by_zero", 32'(div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, q, r, z, lat, pulses, bok);
         $display("vec %0d: %0d / %0d -> q=%0d r=%0d z=%0d lat=%0d", i, vecs[i].a, vecs[i].b, q, r, z, lat);
         check("vec quotient", 32'(q), 32'(vecs[i].q));
         check("vec remainder", 32'(r), 32'(vecs[i].r));
         check("vec div_by_zero", 32'(z), 32'(vecs[i].z));
         check("vec latency", 32'(lat), 32'(vecs[i].lat));
         check("vec done pulses", 32'(pulses), 1);
         check("vec busy window", 32'(bok), 1);
         check("vec quotient held", 32'(quotient), 32'(vecs[i].q));
      end

      // start pulsed mid-CALC is ignored; start during DONE is not queued
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 3;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      $display("midcalc: 100 / 7 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
      check("midcalc latency", 32'(lat), W);
      check("midcalc quotient", 32'(quotient), 14);
      check("midcalc remainder", 32'(remainder), 2);
      dividend = 8'd1;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("start in done not queued", 32'(busy), 0);
      run_op(8'd50, 8'd5, q, r, z, lat, pulses, bok);
      $display("after done: 50 / 5 -> q=%0d r=%0d lat=%0d", q, r, lat);
      check("restart quotient", 32'(q), 10);
      check("restart remainder", 32'(r), 0);
      check("restart latency", 32'(lat), W);

      // reset during the 4th CALC cycle discards the operation
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("midcalc reset: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
      check("midreset busy", 32'(busy), 0);
      check("midreset done", 32'(done), 0);
      check("midreset quotient", 32'(quotient), 0);
      check("midreset remainder", 32'(remainder), 0);
      check("midreset div_by_zero", 32'(div_by_zero), 0);
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) cnt++;
      end
      check("no done after reset", 32'(cnt), 0);

      for (int i = 0; i < 2000; i++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(1, 255));
         if (i == 0) begin a = 8'd255; b = 8'd2; end
         if (i == 1) begin a = 8'd1;   b = 8'd255; end
         run_op(a, b, q, r, z, lat, pulses, bok);
         $display("rand %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", i, a, b, q, r, lat);
         check("rand quotient", 32'(q), 32'(a / b));
         check("rand remainder", 32'(r), 32'(a % b));
         check("rand identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
         check("rand rem below divisor", 32'(r < b), 1);
         check("rand latency", 32'(lat), W);
         check("rand done pulses", 32'(pulses), 1);
         check("rand div_by_zero", 32'(z), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
